// File: rtl/dmemory_bank.sv
// dmemory_bank -- single-port data word RAM with programmable wait states.
//
// Sits between the core's data-access stage and on-chip RAM. Each access
// takes 1+WAIT cycles: the memory array is read and/or written at the
// accepting edge, the optional wait states only delay the completion pulse.
//
// Handshake: a request (i_read and/or i_write high) is accepted on any rising
// edge where o_busy is low; address, op and data are sampled at that edge.
// While o_busy is high requests are dropped, so a requester holds its request
// until it sees o_busy low. o_busy is low during the o_done cycle, which lets
// back-to-back accesses run at one per 1+WAIT cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   i_addr     word address
//   i_read     read request (with i_write: atomic swap)
//   i_write    write request
//   i_data     write data
//   o_data     read data, held until the next error-free read/swap completion
//   o_done     one-cycle completion pulse
//   o_busy     access in progress (wait states), requests ignored
//   o_err      qualifies o_done: address was out of range (>= DEPTH)
//   dbg_state  current FSM state (IDLE=0, WAITING=1, DONE=2)

module dmemory_bank #(
    parameter int WIDTH  = 48,
    parameter int AWIDTH = 15,
    parameter int DEPTH  = 32768,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        dbg_state
);

    localparam int              MAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_N  = 4'(WAIT);
    // One extra bit so DEPTH == 2**AWIDTH is representable.
    localparam logic [AWIDTH:0] DEPTH_N = (AWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  result_q;
    logic              pend_read;
    logic              pend_err;
    logic              accept;
    logic              in_range;
    logic [MAW-1:0]    mem_addr;
    logic [WIDTH-1:0]  rd_word;

    assign accept   = (i_read || i_write) && (state != ST_WAITING);
    assign in_range = ({1'b0, i_addr} < DEPTH_N);
    assign mem_addr = i_addr[MAW-1:0];
    assign rd_word  = mem[mem_addr];

    // Memory array: contents are not touched by reset. A swap reads the old
    // word (rd_word, sampled at this edge) and writes the new one together.
    always_ff @(posedge clk) begin
        if (accept && i_write && in_range) begin
            mem[mem_addr] <= i_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (WAIT_N == 4'd0) ? ST_DONE : ST_WAITING;
                end
            end
            ST_WAITING: begin
                if (cnt <= 4'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_next = (WAIT_N == 4'd0) ? ST_DONE : ST_WAITING;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            result_q  <= '0;
            pend_read <= 1'b0;
            pend_err  <= 1'b0;
            o_data    <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                cnt       <= WAIT_N;
                pend_read <= i_read;
                pend_err  <= !in_range;
                if (i_read && in_range) begin
                    result_q <= rd_word;
                end
            end else if (state == ST_WAITING) begin
                cnt <= cnt - 4'd1;
            end

            // o_data changes only as a good read/swap enters DONE. With no
            // wait states that is the accepting edge itself, so the memory
            // word is taken directly; otherwise the captured result is used.
            if (accept && (WAIT_N == 4'd0) && i_read && in_range) begin
                o_data <= rd_word;
            end else if ((state == ST_WAITING) && (cnt <= 4'd1) &&
                         pend_read && !pend_err) begin
                o_data <= result_q;
            end
        end
    end

    assign o_done    = (state == ST_DONE);
    assign o_busy    = (state == ST_WAITING);
    assign o_err     = o_done && pend_err;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmemory_bank.sv
// tb_dmemory_bank -- directed bench for dmemory_bank.
//
// Four instances: u_w0 (WAIT=0, DEPTH=32768), u_w3 (WAIT=3, DEPTH=1024),
// u_w5 (WAIT=5, DEPTH=1024), u_d1k (WAIT=0, DEPTH=1024). Each has its own
// request inputs and reset. Inputs change 1 time unit after the rising edge
// and outputs are sampled at that same point.

module tb_dmemory_bank;

    localparam int W  = 48;
    localparam int AW = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [4];
    logic [AW-1:0] addr  [4];
    logic          rd    [4];
    logic          wr    [4];
    logic [W-1:0]  din   [4];

    logic [W-1:0] dout0, dout1, dout2, dout3;
    logic         done0, done1, done2, done3;
    logic         busy0, busy1, busy2, busy3;
    logic         err0,  err1,  err2,  err3;
    logic [1:0]   st0,   st1,   st2,   st3;

    dmemory_bank #(.WIDTH(W), .AWIDTH(AW), .DEPTH(32768), .WAIT(0)) u_w0 (
        .clk(clk), .reset_n(rst_n[0]), .i_addr(addr[0]), .i_read(rd[0]),
        .i_write(wr[0]), .i_data(din[0]), .o_data(dout0), .o_done(done0),
        .o_busy(busy0), .o_err(err0), .dbg_state(st0));

    dmemory_bank #(.WIDTH(W), .AWIDTH(AW), .DEPTH(1024), .WAIT(3)) u_w3 (
        .clk(clk), .reset_n(rst_n[1]), .i_addr(addr[1]), .i_read(rd[1]),
        .i_write(wr[1]), .i_data(din[1]), .o_data(dout1), .o_done(done1),
        .o_busy(busy1), .o_err(err1), .dbg_state(st1));

    dmemory_bank #(.WIDTH(W), .AWIDTH(AW), .DEPTH(1024), .WAIT(5)) u_w5 (
        .clk(clk), .reset_n(rst_n[2]), .i_addr(addr[2]), .i_read(rd[2]),
        .i_write(wr[2]), .i_data(din[2]), .o_data(dout2), .o_done(done2),
        .o_busy(busy2), .o_err(err2), .dbg_state(st2));

    dmemory_bank #(.WIDTH(W), .AWIDTH(AW), .DEPTH(1024), .WAIT(0)) u_d1k (
        .clk(clk), .reset_n(rst_n[3]), .i_addr(addr[3]), .i_read(rd[3]),
        .i_write(wr[3]), .i_data(din[3]), .o_data(dout3), .o_done(done3),
        .o_busy(busy3), .o_err(err3), .dbg_state(st3));

    function automatic logic [W-1:0] f_data(input int k);
        case (k)
            0: return dout0;
            1: return dout1;
            2: return dout2;
            default: return dout3;
        endcase
    endfunction

    function automatic logic f_done(input int k);
        case (k)
            0: return done0;
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    function automatic logic f_busy(input int k);
        case (k)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    function automatic logic f_err(input int k);
        case (k)
            0: return err0;
            1: return err1;
            2: return err2;
            default: return err3;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model [16];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (done0) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
        rd[k]   = r;
        wr[k]   = w;
        addr[k] = a;
        din[k]  = d;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 1'b0, '0, '0);
    endtask

    // One complete access: present the request for one edge, wait (bounded)
    // for o_done, return o_data/o_err from the done cycle, then leave it.
    task automatic access(input int k, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [W-1:0] d,
                          output logic [W-1:0] q, output logic e);
        int n;
        drive(k, r, w, a, d);
        step();
        idle(k);
        n = 0;
        while (!f_done(k) && n < 40) begin
            step();
            n++;
        end
        check("access_done_seen", f_done(k), 1);
        q = f_data(k);
        e = f_err(k);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] q;
        logic         e;
        int           busy_n;
        int           done_n;
        int           accepted;
        int           op;
        logic [3:0]   a;
        logic [63:0]  r64;
        logic [W-1:0] d;

        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0;
            idle(k);
        end
        step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            check("rst_done", f_done(k), 0);
            check("rst_busy", f_busy(k), 0);
            check("rst_err",  f_err(k),  0);
            check("rst_data", f_data(k), 0);
        end
        for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
        step();

        // WAIT=0: write then read on the next edge
        drive(0, 1'b0, 1'b1, 15'h0010, 48'h0000_1234_5678);
        step();
        check("w0_wr_done", done0, 1);
        check("w0_wr_busy", busy0, 0);
        check("w0_wr_err",  err0,  0);
        drive(0, 1'b1, 1'b0, 15'h0010, '0);
        step();
        check("w0_rd_done", done0, 1);
        check("w0_rd_busy", busy0, 0);
        check("w0_rd_data", dout0, 48'h0000_1234_5678);
        idle(0);
        step();
        check("w0_done_drop", done0, 0);
        check("w0_busy_idle", busy0, 0);

        // WAIT=3: busy for 3 cycles, dropped request, re-issue in done cycle
        access(1, 1'b0, 1'b1, 15'h0010, 48'h0000_1111_2222, q, e);
        drive(1, 1'b1, 1'b0, 15'h0010, '0);
        step();
        idle(1);
        busy_n = 0;
        done_n = 0;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("w3_busy_%0d", i), busy1, (i != 4 && i != 8));
            check($sformatf("w3_done_%0d", i), done1, (i == 4 || i == 8));
            if (i < 8) begin
                if (busy1) busy_n++;
                if (done1) done_n++;
            end
            if (i == 2) drive(1, 1'b1, 1'b0, 15'h0010, '0);
            if (i == 3) idle(1);
            if (i == 4) begin
                check("w3_data_first", dout1, 48'h0000_1111_2222);
                drive(1, 1'b1, 1'b0, 15'h0010, '0);
            end
            if (i == 5) idle(1);
            if (i < 8) step();
        end
        check("w3_busy_count", busy_n, 6);
        check("w3_done_count", done_n, 1);
        check("w3_data_second", dout1, 48'h0000_1111_2222);
        step();
        check("w3_done_drop", done1, 0);

        // Swap at the top address
        access(0, 1'b0, 1'b1, 15'h7FFF, 48'hAAAA_AAAA_AAAA, q, e);
        access(0, 1'b1, 1'b1, 15'h7FFF, 48'h5555_5555_5555, q, e);
        check("swap_old", q, 48'hAAAA_AAAA_AAAA);
        check("swap_err", e, 0);
        access(0, 1'b1, 1'b0, 15'h7FFF, '0, q, e);
        check("swap_new", q, 48'h5555_5555_5555);

        // DEPTH=1024: out-of-range accesses
        access(3, 1'b0, 1'b1, 15'h0000, 48'h0000_0000_BEEF, q, e);
        access(3, 1'b1, 1'b0, 15'h0000, '0, q, e);
        check("d1k_rd0", q, 48'h0000_0000_BEEF);
        access(3, 1'b1, 1'b0, 15'h0400, '0, q, e);
        check("d1k_oor_err", e, 1);
        check("d1k_oor_data", q, 48'h0000_0000_BEEF);
        check("d1k_err_idle", err3, 0);
        access(3, 1'b0, 1'b1, 15'h0400, 48'h0000_0000_DEAD, q, e);
        check("d1k_oor_wr_err", e, 1);
        access(3, 1'b1, 1'b0, 15'h0000, '0, q, e);
        check("d1k_no_alias", q, 48'h0000_0000_BEEF);
        check("d1k_rd_err", e, 0);

        // WAIT=5: reset in cycle 2 of a read
        access(2, 1'b0, 1'b1, 15'h0020, 48'h0000_0000_0077, q, e);
        access(2, 1'b1, 1'b0, 15'h0020, '0, q, e);
        check("w5_pre_data", q, 48'h0000_0000_0077);
        drive(2, 1'b1, 1'b0, 15'h0020, '0);
        step();
        idle(2);
        step();
        check("w5_busy_before_rst", busy2, 1);
        #2;
        rst_n[2] = 1'b0;
        #1;
        check("w5_rst_busy", busy2, 0);
        check("w5_rst_done", done2, 0);
        check("w5_rst_err",  err2,  0);
        check("w5_rst_data", dout2, 0);
        step();
        rst_n[2] = 1'b1;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (done2) done_n++;
            step();
        end
        check("w5_no_done_after_rst", done_n, 0);
        access(2, 1'b1, 1'b0, 15'h0020, '0, q, e);
        check("w5_after_rst_data", q, 48'h0000_0000_0077);
        check("w5_after_rst_err", e, 0);

        // WAIT=0: random read/write/swap against a reference model
        for (int i = 0; i < 16; i++) begin
            r64 = {$urandom(), $urandom()};
            model[i] = r64[W-1:0];
            drive(0, 1'b0, 1'b1, AW'(i), model[i]);
            step();
        end
        idle(0);
        step();
        done_cnt = 0;
        accepted = 0;
        for (int i = 0; i < 1000; i++) begin
            op  = $urandom_range(0, 3);
            a   = 4'($urandom_range(0, 15));
            r64 = {$urandom(), $urandom()};
            d   = r64[W-1:0];
            if (op == 0 || op == 2) exp_q.push_back(model[a]);
            if (op == 1 || op == 2) model[a] = d;
            if (op != 3) accepted++;
            drive(0, (op == 0 || op == 2), (op == 1 || op == 2), AW'(a), d);
            step();
            check("rnd_done", done0, (op != 3));
            if ((op == 0 || op == 2) && exp_q.size() > 0) begin
                check("rnd_data", dout0, exp_q.pop_front());
            end
        end
        idle(0);
        step();
        check("rnd_done_count", done_cnt, accepted);
        check("rnd_queue_empty", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
